// File: rtl/pmci_qsfp_telem_pkg.sv
// Shared types and constants for the QSFP telemetry poller.
package pmci_qsfp_telem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CH_START,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_NEXT
    } state_t;

    // Byte distance between consecutive 32-bit telemetry registers
    localparam int unsigned REG_STRIDE          = 4;
    localparam int unsigned TIMEOUT_DEFAULT     = 256;
    localparam int unsigned POLL_PERIOD_DEFAULT = 100000;

endpackage

// File: rtl/pmci_telem_shadow_ram.sv
// Shadow copy of the telemetry registers: one write port, one registered
// read port. A read colliding with a write to the same word returns the
// previous contents. Indices past the end of the array read as zero.
module pmci_telem_shadow_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned AW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [31:0]   i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic [31:0]   o_rd_data,
    output logic          o_rd_valid
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;
    logic        r_rd_valid;
    logic        w_rd_in_range;

    assign w_rd_in_range = (i_rd_idx < AW'(DEPTH));
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;

    // Array update and registered read (old data on same-cycle collision)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_idx] <= i_wr_data;
            end
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_in_range ? r_mem[i_rd_idx[IW-1:0]] : '0;
            end
        end
    end

endmodule

// File: rtl/pmci_qsfp_telemetry_poller.sv
// Periodic QSFP telemetry scanner: walks every enabled channel window over
// a single-outstanding AVMM read master and caches results in a shadow RAM
// that the host can read with fixed one-cycle latency.
module pmci_qsfp_telemetry_poller
    import pmci_qsfp_telem_pkg::*;
#(
    parameter int unsigned NUM_QSFP    = 2,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned POLL_PERIOD = POLL_PERIOD_DEFAULT,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [NUM_QSFP-1:0]                 i_ch_en,
    input  logic [NUM_QSFP*ADDR_W-1:0]          i_ch_base,
    input  logic                                i_scan_trig,
    input  logic                                i_err_clr,
    output logic [ADDR_W-1:0]                   o_avmm_address,
    output logic                                o_avmm_read,
    input  logic                                i_avmm_waitrequest,
    input  logic                                i_avmm_readdatavalid,
    input  logic [31:0]                         i_avmm_readdata,
    input  logic                                i_csr_rd,
    input  logic [$clog2(NUM_QSFP*NUM_REGS):0]  i_csr_rd_addr,
    output logic [31:0]                         o_csr_rd_data,
    output logic                                o_csr_rd_valid,
    output logic                                o_scan_busy,
    output logic [15:0]                         o_scan_count,
    output logic [NUM_QSFP-1:0]                 o_ch_err
);

    localparam int unsigned DEPTH = NUM_QSFP * NUM_REGS;
    localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW    = $clog2(DEPTH) + 1;
    localparam int unsigned CW    = (NUM_QSFP > 1) ? $clog2(NUM_QSFP) : 1;
    localparam int unsigned RW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned PW    = $clog2(POLL_PERIOD);

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_c, w_c_nxt;
    logic [RW-1:0]       r_r, w_r_nxt;
    logic [TW-1:0]       r_tmo;
    logic [PW-1:0]       r_poll;
    logic                r_pending;
    logic                r_busy;
    logic [15:0]         r_count;
    logic [NUM_QSFP-1:0] r_err;
    logic                r_rdv;
    logic [31:0]         r_rdata;

    logic                w_start, w_done, w_wr_en, w_set_err, w_poll_wrap;
    logic [ADDR_W-1:0]   w_ch_base, w_addr;
    logic [IW-1:0]       w_wr_idx;

    assign w_poll_wrap = (r_poll == PW'(POLL_PERIOD - 1));
    assign w_ch_base   = i_ch_base[int'(r_c) * ADDR_W +: ADDR_W];
    assign w_addr      = w_ch_base + ADDR_W'(r_r) * ADDR_W'(REG_STRIDE);
    assign w_wr_idx    = IW'(r_c) * IW'(NUM_REGS) + IW'(r_r);

    assign o_avmm_read    = (r_state == ST_ISSUE);
    assign o_avmm_address = o_avmm_read ? w_addr : '0;
    assign o_scan_busy    = r_busy;
    assign o_scan_count   = r_count;
    assign o_ch_err       = r_err;

    // Free-running poll timer; requests collapse into a single pending flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_poll    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_poll <= w_poll_wrap ? '0 : r_poll + 1'b1;
            if (i_scan_trig || w_poll_wrap) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Next-state and datapath strobes for the scan sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_r_nxt     = r_r;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_wr_en     = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_start     = 1'b1;
                    w_c_nxt     = '0;
                    w_state_nxt = ST_CH_START;
                end
            end
            ST_CH_START: begin
                if (i_ch_en[r_c]) begin
                    w_r_nxt     = '0;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    // Parking r on the last register makes NEXT skip the channel
                    w_r_nxt     = RW'(NUM_REGS - 1);
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_ISSUE: begin
                if (!i_avmm_waitrequest) begin
                    w_state_nxt = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (r_rdv) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = ST_NEXT;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_r < RW'(NUM_REGS - 1)) begin
                    w_r_nxt     = r_r + 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (r_c < CW'(NUM_QSFP - 1)) begin
                    w_c_nxt     = r_c + 1'b1;
                    w_state_nxt = ST_CH_START;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, indices, timeout counter and scan status
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_r     <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_r     <= w_r_nxt;
            if (r_state == ST_ISSUE) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT_DATA) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_done) begin
                r_busy <= 1'b0;
            end
            if (w_done) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Sticky per-channel timeout flags; a same-cycle set overrides the clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= '0;
        end else begin
            if (i_err_clr) begin
                r_err <= '0;
            end
            if (w_set_err) begin
                r_err[r_c] <= 1'b1;
            end
        end
    end

    // Response capture register; only consumed while waiting for data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdv   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdv   <= i_avmm_readdatavalid;
            r_rdata <= i_avmm_readdata;
        end
    end

    pmci_telem_shadow_ram #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_shadow (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_data  (r_rdata),
        .i_rd_en    (i_csr_rd),
        .i_rd_idx   (i_csr_rd_addr),
        .o_rd_data  (o_csr_rd_data),
        .o_rd_valid (o_csr_rd_valid)
    );

endmodule

// File: tb/tb_pmci_qsfp_telemetry_poller.sv
// Directed bench for the QSFP telemetry poller: 2 channels x 4 registers,
// AVMM slave answers with (address ^ data_xor) two cycles after acceptance.
module tb_pmci_qsfp_telemetry_poller;

    localparam int unsigned LAT = 2;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ch_en;
    logic [41:0] ch_base;
    logic        scan_trig;
    logic        err_clr;
    logic [20:0] avmm_address;
    logic        avmm_read;
    logic        avmm_waitrequest;
    logic        avmm_readdatavalid;
    logic [31:0] avmm_readdata;
    logic        csr_rd;
    logic [3:0]  csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_rd_valid;
    logic        scan_busy;
    logic [15:0] scan_count;
    logic [1:0]  ch_err;

    pmci_qsfp_telemetry_poller #(
        .NUM_QSFP    (2),
        .NUM_REGS    (4),
        .ADDR_W      (21),
        .POLL_PERIOD (100000),
        .TIMEOUT     (32)
    ) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_ch_en              (ch_en),
        .i_ch_base            (ch_base),
        .i_scan_trig          (scan_trig),
        .i_err_clr            (err_clr),
        .o_avmm_address       (avmm_address),
        .o_avmm_read          (avmm_read),
        .i_avmm_waitrequest   (avmm_waitrequest),
        .i_avmm_readdatavalid (avmm_readdatavalid),
        .i_avmm_readdata      (avmm_readdata),
        .i_csr_rd             (csr_rd),
        .i_csr_rd_addr        (csr_rd_addr),
        .o_csr_rd_data        (csr_rd_data),
        .o_csr_rd_valid       (csr_rd_valid),
        .o_scan_busy          (scan_busy),
        .o_scan_count         (scan_count),
        .o_ch_err             (ch_err)
    );

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] exp_data;
    } csr_vec_t;

    localparam int NV = 8;
    csr_vec_t vecs [NV];

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    // Slave control (written by the main thread only)
    logic        drop_en  = 1'b0;
    logic [20:0] drop_addr = '0;
    logic [31:0] data_xor = '0;
    int unsigned late_req = 0;
    // Slave bookkeeping (written by the slave thread only)
    int unsigned late_done = 0;
    logic [20:0] acc_addr [$];
    int unsigned acc_cyc  [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // AVMM slave model: one outstanding read, fixed response latency
    initial begin : slave
        logic [31:0] resp;
        avmm_readdatavalid = 1'b0;
        avmm_readdata      = '0;
        forever begin
            @(negedge clk);
            if (late_req != late_done) begin
                @(posedge clk); #1;
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = 32'hDEAD_0000;
                @(posedge clk); #1;
                avmm_readdatavalid = 1'b0;
                late_done++;
            end else if (rst_n && avmm_read && !avmm_waitrequest) begin
                acc_addr.push_back(avmm_address);
                acc_cyc.push_back(cyc);
                if (!(drop_en && avmm_address == drop_addr)) begin
                    resp = {11'b0, avmm_address} ^ data_xor;
                    @(posedge clk);
                    repeat (LAT - 1) @(posedge clk);
                    #1;
                    avmm_readdatavalid = 1'b1;
                    avmm_readdata      = resp;
                    @(posedge clk); #1;
                    avmm_readdatavalid = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1 scan_trig = 1'b1;
        @(posedge clk); #1 scan_trig = 1'b0;
    endtask

    task automatic wait_count(input logic [15:0] target, input int unsigned budget);
        int unsigned k = 0;
        while (scan_count != target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("scan_count_reached", {16'b0, scan_count}, {16'b0, target});
        check("busy_low_at_done", {31'b0, scan_busy}, 32'd0);
    endtask

    task automatic wait_read(input int unsigned budget);
        int unsigned k = 0;
        @(negedge clk);
        while (!avmm_read && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("read_seen", {31'b0, avmm_read}, 32'd1);
    endtask

    task automatic csr_check1(input string name, input logic [3:0] idx, input logic [31:0] exp);
        @(posedge clk); #1;
        csr_rd      = 1'b1;
        csr_rd_addr = idx;
        @(posedge clk); #1;
        csr_rd = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, {31'b0, csr_rd_valid}, 32'd1);
        check({name, "_data"}, csr_rd_data, exp);
    endtask

    // Back-to-back shadow reads from the vector table
    task automatic run_csr_table(input string tag);
        for (int i = 0; i <= NV; i++) begin
            @(posedge clk); #1;
            if (i < NV) begin
                csr_rd      = 1'b1;
                csr_rd_addr = vecs[i].idx;
            end else begin
                csr_rd = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("%s_valid_idx%0d", tag, vecs[i-1].idx), {31'b0, csr_rd_valid}, 32'd1);
                check($sformatf("%s_data_idx%0d", tag, vecs[i-1].idx), csr_rd_data, vecs[i-1].exp_data);
            end
        end
        @(negedge clk);
        check({tag, "_valid_drop"}, {31'b0, csr_rd_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avmm_read"}, {31'b0, avmm_read}, 32'd0);
        check({tag, "_avmm_address"}, {11'b0, avmm_address}, 32'd0);
        check({tag, "_csr_valid"}, {31'b0, csr_rd_valid}, 32'd0);
        check({tag, "_csr_data"}, csr_rd_data, 32'd0);
        check({tag, "_scan_busy"}, {31'b0, scan_busy}, 32'd0);
        check({tag, "_scan_count"}, {16'b0, scan_count}, 32'd0);
        check({tag, "_ch_err"}, {30'b0, ch_err}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin : main
        int unsigned s, first_busy, first_read, busy_cyc, n_in_ch1, n_1000, stable;

        // Shadow index -> data, slave returns the read address as data
        vecs[0] = '{4'd0,  32'h0000_1000};
        vecs[1] = '{4'd1,  32'h0000_1004};
        vecs[2] = '{4'd3,  32'h0000_100C};
        vecs[3] = '{4'd5,  32'h0000_2004};
        vecs[4] = '{4'd6,  32'h0000_2008};
        vecs[5] = '{4'd7,  32'h0000_200C};
        vecs[6] = '{4'd8,  32'h0000_0000};
        vecs[7] = '{4'd15, 32'h0000_0000};

        rst_n            = 1'b0;
        ch_en            = 2'b11;
        ch_base          = {21'h02000, 21'h01000};
        scan_trig        = 1'b0;
        err_clr          = 1'b0;
        avmm_waitrequest = 1'b0;
        csr_rd           = 1'b0;
        csr_rd_addr      = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("init");
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: full scan, latency checks and shadow contents
        s = acc_addr.size();
        @(posedge clk); #1 scan_trig = 1'b1;
        @(posedge clk); #1 scan_trig = 1'b0;
        first_busy = 0; first_read = 0; busy_cyc = 0;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            if (scan_busy) begin
                busy_cyc++;
                if (first_busy == 0) first_busy = k;
            end
            if (avmm_read && first_read == 0) first_read = k;
            if (first_busy != 0 && !scan_busy) break;
        end
        check("t1_trig_to_busy", first_busy, 32'd2);
        check("t1_trig_to_read", first_read, 32'd3);
        // CH_START per channel plus (3+LAT) per register
        check("t1_busy_cycles", busy_cyc, 32'd42);
        check("t1_scan_count", {16'b0, scan_count}, 32'd1);
        check("t1_ch_err", {30'b0, ch_err}, 32'd0);
        check("t1_accepts", acc_addr.size() - s, 32'd8);
        if (acc_addr.size() >= s + 2)
            check("t1_reg_spacing", acc_cyc[s+1] - acc_cyc[s], 32'd5);
        run_csr_table("t1");

        // 2: channel 1 disabled, from a fresh reset
        do_reset();
        ch_en = 2'b01;
        s = acc_addr.size();
        @(posedge clk); #1 scan_trig = 1'b1;
        @(posedge clk); #1 scan_trig = 1'b0;
        busy_cyc = 0;
        for (int k = 1; k < 400; k++) begin
            @(negedge clk);
            if (scan_busy) busy_cyc++;
            if (busy_cyc != 0 && !scan_busy) break;
        end
        check("t2_busy_cycles", busy_cyc, 32'd23);
        check("t2_scan_count", {16'b0, scan_count}, 32'd1);
        n_in_ch1 = 0;
        for (int i = int'(s); i < acc_addr.size(); i++)
            if (acc_addr[i] >= 21'h02000 && acc_addr[i] <= 21'h0200C) n_in_ch1++;
        check("t2_ch1_accesses", n_in_ch1, 32'd0);
        check("t2_accepts", acc_addr.size() - s, 32'd4);
        for (int i = 4; i < 8; i++)
            csr_check1($sformatf("t2_shadow%0d", i), 4'(i), 32'd0);
        csr_check1("t2_shadow2", 4'd2, 32'h0000_1008);

        // 3: timeout on 0x1008, late response, error clear
        ch_en     = 2'b11;
        drop_en   = 1'b1;
        drop_addr = 21'h01008;
        data_xor  = 32'hA500_0000;
        pulse_trig();
        wait_count(16'd2, 600);
        check("t3_ch_err", {30'b0, ch_err}, 32'd1);
        csr_check1("t3_shadow2_kept", 4'd2, 32'h0000_1008);
        csr_check1("t3_shadow3_new", 4'd3, 32'hA500_100C);
        csr_check1("t3_shadow6_new", 4'd6, 32'hA500_2008);
        drop_en = 1'b0;
        late_req++;
        repeat (6) @(negedge clk);
        csr_check1("t3_shadow2_late", 4'd2, 32'h0000_1008);
        check("t3_ch_err_held", {30'b0, ch_err}, 32'd1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        check("t3_ch_err_cleared", {30'b0, ch_err}, 32'd0);
        data_xor = '0;

        // 4: waitrequest held for 10 cycles on the first read
        avmm_waitrequest = 1'b1;
        s = acc_addr.size();
        pulse_trig();
        wait_read(50);
        stable = 0;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) @(negedge clk);
            if (avmm_read && avmm_address == 21'h01000) stable++;
            if (k == 9) begin
                @(posedge clk); #1 avmm_waitrequest = 1'b0;
            end
        end
        check("t4_stable_cycles", stable, 32'd11);
        wait_count(16'd3, 400);
        n_1000 = 0;
        for (int i = int'(s); i < acc_addr.size(); i++)
            if (acc_addr[i] == 21'h01000) n_1000++;
        check("t4_first_read_once", n_1000, 32'd1);
        check("t4_accepts", acc_addr.size() - s, 32'd8);

        // 5: three requests while busy collapse into one extra scan
        do_reset();
        pulse_trig();
        repeat (5) @(negedge clk);
        check("t5_busy_before_retrig", {31'b0, scan_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            pulse_trig();
            repeat (3) @(negedge clk);
        end
        wait_count(16'd1, 400);
        wait_count(16'd2, 400);
        repeat (100) @(negedge clk);
        check("t5_no_third_scan", {16'b0, scan_count}, 32'd2);
        check("t5_idle_after", {31'b0, scan_busy}, 32'd0);
        run_csr_table("t5");

        // 6: reset pulse while waiting for read data, then a clean rescan
        pulse_trig();
        wait_read(50);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_midscan");
        repeat (10) @(negedge clk);
        check("t6_still_idle", {31'b0, scan_busy}, 32'd0);
        pulse_trig();
        wait_count(16'd1, 400);
        check("t6_ch_err", {30'b0, ch_err}, 32'd0);
        run_csr_table("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
